instruction_memory_loader: RTL and testbench

//  - Writer side of the byte-wide instruction memory. Accepts a byte stream with a valid/ready handshake.
//  - Writes the bytes in arrival order from address 0 up. Bytes are big-endian per instruction: the MSB byte arrives first, at address 4k.
//  - Zero-fills all remaining locations, then releases the core from hold.
//  - Sits between the boot/debug byte source and the instruction memory write port.

---
 rtl/instruction_memory_loader.sv | 214 +++++++++++++++++++++
 tb/tb_instruction_memory_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader
//   Writer side of the byte-wide instruction memory. A boot/debug source
//   streams an image over a valid/ready handshake. Bytes are written in arrival
//   order from address 0 up (big-endian per instruction: MSB byte at 4k). The
//   rest of the memory is then zero-filled and the core is released from hold.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, one extra checksum byte follows the image. The image is
//     accepted only if (sum of image bytes + checksum) mod 256 == 0. The
//     checksum byte itself is never written to memory.
//
//   Write port timing: a byte accepted on edge N is presented on the write
//   port (o_MemWrEn/o_MemWrAddr/o_MemWrData) for the cycle after edge N.
//   Zero-fill writes use the same registered path, one per cycle.
// -----------------------------------------------------------------------------
module instruction_memory_loader #(
    parameter int INST_MEM_WIDTH      = 8,
    parameter int INST_MEM_DEPTH      = 32,
    parameter int INST_MEM_ADDR_WIDTH = $clog2(INST_MEM_DEPTH)
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Start,
    input  logic [INST_MEM_ADDR_WIDTH:0]   i_Length,
    input  logic                           i_ByteValid,
    input  logic [INST_MEM_WIDTH-1:0]      i_ByteData,
    output logic                           o_ByteReady,
    output logic                           o_MemWrEn,
    output logic [INST_MEM_ADDR_WIDTH-1:0] o_MemWrAddr,
    output logic [INST_MEM_WIDTH-1:0]      o_MemWrData,
    output logic                           o_CpuHold,
    output logic                           o_Done,
    output logic                           o_Error
);

    // The counter is one bit wider than the address so it can reach DEPTH
    // without wrapping; reaching DEPTH marks the end of the fill.
    localparam int                CNT_W   = INST_MEM_ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(INST_MEM_DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t                          r_State;
    state_t                          w_NextState;
    logic [CNT_W-1:0]                r_Count;
    logic [CNT_W-1:0]                w_NextCount;
    logic [CNT_W-1:0]                r_Length;
    logic [CNT_W-1:0]                w_NextLength;
    logic                            r_Error;
    logic                            w_NextError;

    // Registered write port (one stage after the handshake / fill decision)
    logic                            r_WrEn_p1;
    logic [INST_MEM_ADDR_WIDTH-1:0]  r_WrAddr_p1;
    logic [INST_MEM_WIDTH-1:0]       r_WrData_p1;
    logic                            w_WrEn;
    logic [INST_MEM_ADDR_WIDTH-1:0]  w_WrAddr;
    logic [INST_MEM_WIDTH-1:0]       w_WrData;

    logic                            w_Xfer;
    logic                            w_LastByte;
    logic                            w_LenBad;

`ifdef LOADER_CHECKSUM_EN
    logic [INST_MEM_WIDTH-1:0]       r_Sum;
    logic [INST_MEM_WIDTH-1:0]       w_NextSum;
    logic [INST_MEM_WIDTH-1:0]       w_SumCheck;

    assign o_ByteReady = (r_State == S_LOAD) || (r_State == S_CHECK);
    // Adding the checksum byte to the running sum must wrap to zero.
    assign w_SumCheck  = r_Sum + i_ByteData;
`else
    assign o_ByteReady = (r_State == S_LOAD);
`endif

    assign w_Xfer      = i_ByteValid && o_ByteReady;
    assign w_LastByte  = (r_Count == (r_Length - ONE_C));
    // Image must fit in memory and be a whole number of 32-bit instructions.
    assign w_LenBad    = (i_Length > DEPTH_C) || (i_Length[1:0] != 2'b00);

    assign o_CpuHold   = (r_State != S_DONE);
    assign o_Done      = (r_State == S_DONE);
    assign o_Error     = r_Error;
    assign o_MemWrEn   = r_WrEn_p1;
    assign o_MemWrAddr = r_WrAddr_p1;
    assign o_MemWrData = r_WrData_p1;

    // Next-state, counter, error and write-request decode.
    always_comb begin
        w_NextState  = r_State;
        w_NextCount  = r_Count;
        w_NextLength = r_Length;
        w_NextError  = r_Error;
        w_WrEn       = 1'b0;
        w_WrAddr     = r_Count[INST_MEM_ADDR_WIDTH-1:0];
        w_WrData     = '0;
`ifdef LOADER_CHECKSUM_EN
        w_NextSum    = r_Sum;
`endif

        case (r_State)
            S_IDLE, S_DONE: begin
                if (i_Start) begin
                    w_NextError = 1'b0;
                    w_NextCount = '0;
`ifdef LOADER_CHECKSUM_EN
                    w_NextSum   = '0;
`endif
                    if (w_LenBad) begin
                        w_NextError = 1'b1;
                        w_NextState = S_IDLE;
                    end else if (i_Length == '0) begin
                        w_NextState = S_FILL;
                    end else begin
                        w_NextLength = i_Length;
                        w_NextState  = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (w_Xfer) begin
                    w_WrEn      = 1'b1;
                    w_WrData    = i_ByteData;
                    w_NextCount = r_Count + ONE_C;
`ifdef LOADER_CHECKSUM_EN
                    w_NextSum   = r_Sum + i_ByteData;
                    if (w_LastByte) begin
                        w_NextState = S_CHECK;
                    end
`else
                    // A full image enters FILL with the counter already at
                    // depth: no zero writes, just one cycle for the last data
                    // write to leave the port before DONE is raised.
                    if (w_LastByte) begin
                        w_NextState = S_FILL;
                    end
`endif
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_Xfer) begin
                    if (w_SumCheck != '0) begin
                        w_NextError = 1'b1;
                        w_NextState = S_IDLE;
                    end else begin
                        w_NextState = S_FILL;
                    end
                end
            end
`endif

            S_FILL: begin
                if (r_Count == DEPTH_C) begin
                    w_NextState = S_DONE;
                end else begin
                    w_WrEn      = 1'b1;
                    w_NextCount = r_Count + ONE_C;
                end
            end

            default: begin
                w_NextState = S_IDLE;
            end
        endcase
    end

    // Control state, counter, sticky error and the write-port stage.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State     <= S_IDLE;
            r_Count     <= '0;
            r_Error     <= 1'b0;
            r_WrEn_p1   <= 1'b0;
            r_WrAddr_p1 <= '0;
            r_WrData_p1 <= '0;
        end else begin
            r_State     <= w_NextState;
            r_Count     <= w_NextCount;
            r_Error     <= w_NextError;
            r_WrEn_p1   <= w_WrEn;
            r_WrAddr_p1 <= w_WrAddr;
            r_WrData_p1 <= w_WrData;
        end
    end

    // Image length (and running sum) are loaded at start and need no reset.
    always_ff @(posedge i_Clk) begin
        r_Length <= w_NextLength;
`ifdef LOADER_CHECKSUM_EN
        r_Sum    <= w_NextSum;
`endif
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory_loader
//   Self-checking bench. The reference model is the memory image itself:
//   the streamed bytes at addresses 0..Length-1 followed by zeros up to the
//   top of memory, written in address order with each data write one cycle
//   after its handshake. Honors LOADER_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_instruction_memory_loader;

    localparam int W  = 8;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          i_Clk = 1'b0;
    logic          i_Reset;
    logic          i_Start;
    logic [AW:0]   i_Length;
    logic          i_ByteValid;
    logic [W-1:0]  i_ByteData;
    logic          o_ByteReady;
    logic          o_MemWrEn;
    logic [AW-1:0] o_MemWrAddr;
    logic [W-1:0]  o_MemWrData;
    logic          o_CpuHold;
    logic          o_Done;
    logic          o_Error;

    always #5 i_Clk = ~i_Clk;

    instruction_memory_loader #(
        .INST_MEM_WIDTH      (W),
        .INST_MEM_DEPTH      (D),
        .INST_MEM_ADDR_WIDTH (AW)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Start     (i_Start),
        .i_Length    (i_Length),
        .i_ByteValid (i_ByteValid),
        .i_ByteData  (i_ByteData),
        .o_ByteReady (o_ByteReady),
        .o_MemWrEn   (o_MemWrEn),
        .o_MemWrAddr (o_MemWrAddr),
        .o_MemWrData (o_MemWrData),
        .o_CpuHold   (o_CpuHold),
        .o_Done      (o_Done),
        .o_Error     (o_Error)
    );

    int   n_vec = 0;
    int   n_err = 0;

    // Monitor state: every write seen on the port, with the cycle it appeared
    // in and whether a handshake happened in the cycle before it.
    int   cyc = 0;
    int   done_rise = -1;
    logic done_prev = 1'b0;
    logic hs_prev = 1'b0;
    int   wq_addr[$];
    int   wq_data[$];
    bit   wq_hs[$];
    int   wq_cyc[$];

    logic [7:0] img [0:D-1];
    bit   post_hold, post_done, post_err, timed_out;

    always @(negedge i_Clk) begin
        if (o_MemWrEn) begin
            wq_addr.push_back(int'(o_MemWrAddr));
            wq_data.push_back(int'(o_MemWrData));
            wq_hs.push_back(hs_prev);
            wq_cyc.push_back(cyc);
        end
        if (o_Done && !done_prev) done_rise <= cyc;
        done_prev <= o_Done;
        hs_prev   <= i_ByteValid && o_ByteReady;
        cyc       <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_hs.delete();
        wq_cyc.delete();
    endtask

    // Drive one load: start, stream len bytes (plus checksum byte when the
    // feature is built), then wait for DONE or an error. cs_in < 0 selects the
    // correct checksum for the current image.
    task automatic run_load(input int len, input int vmode, input bit poke, input int cs_in);
        int n, idx, budget, sum;
        bit v, tog, hs;
        logic [7:0] cs;
        clear_log();
        sum = 0;
        for (int i = 0; i < len; i++) sum += int'(img[i]);
        cs = (cs_in < 0) ? 8'((256 - (sum % 256)) % 256) : 8'(cs_in);
        n = len;
`ifdef LOADER_CHECKSUM_EN
        if (len > 0) n = len + 1;
`endif
        i_Start     = 1'b1;
        i_Length    = 6'(len);
        i_ByteValid = 1'($urandom_range(0, 1));
        i_ByteData  = 8'($urandom);
        @(posedge i_Clk); #1;
        i_Start   = 1'b0;
        post_hold = o_CpuHold;
        post_done = o_Done;
        post_err  = o_Error;
        idx = 0; budget = 0; tog = 1'b1;
        while (idx < n && budget < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_ByteValid = v;
            i_ByteData  = (idx < len) ? img[idx] : cs;
            if (poke) begin
                i_Start  = 1'($urandom_range(0, 1));
                i_Length = 6'($urandom_range(0, 63));
            end
            @(negedge i_Clk);
            hs = i_ByteValid && o_ByteReady;
            @(posedge i_Clk); #1;
            if (hs) idx++;
            budget++;
        end
        i_ByteValid = 1'b0;
        i_Start     = 1'b0;
        timed_out   = (idx < n);
        for (int k = 0; k < 80 && !o_Done && !o_Error; k++) begin
            @(posedge i_Clk); #1;
        end
        repeat (3) begin @(posedge i_Clk); #1; end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1; i_Start = 1'b0; i_Length = '0;
        i_ByteValid = 1'b1; i_ByteData = 8'hA5;
        repeat (3) begin @(posedge i_Clk); #1; end
        n_vec++; if (o_ByteReady !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", o_ByteReady); end
        n_vec++; if (o_MemWrEn !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", o_MemWrEn); end
        n_vec++; if (o_MemWrAddr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", o_MemWrAddr); end
        n_vec++; if (o_MemWrData !== 8'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", o_MemWrData); end
        n_vec++; if (o_CpuHold !== 1'b1) begin n_err++; $display("FAIL reset_hold: got %b want 1", o_CpuHold); end
        n_vec++; if (o_Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_Done); end
        n_vec++; if (o_Error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", o_Error); end
        i_Reset = 1'b0;
        clear_log();
        repeat (4) begin @(posedge i_Clk); #1; end
        n_vec++; if (wq_addr.size() !== 0) begin n_err++; $display("FAIL idle_valid_writes: got %0d want 0", wq_addr.size()); end
        n_vec++; if (o_ByteReady !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", o_ByteReady); end
        i_ByteValid = 1'b0;
    endtask

    task automatic test_length_errors();
        int lens[4];
        int l;
        lens[0] = 6;
        lens[1] = 36;
        for (int j = 2; j < 4; j++) begin
            l = $urandom_range(0, 63);
            while (!(l > D || (l % 4) != 0)) l = $urandom_range(0, 63);
            lens[j] = l;
        end
        for (int j = 0; j < 4; j++) begin
            clear_log();
            i_Start = 1'b1; i_Length = 6'(lens[j]); i_ByteValid = 1'b1; i_ByteData = 8'($urandom);
            @(posedge i_Clk); #1;
            i_Start = 1'b0;
            n_vec++; if (o_Error !== 1'b1) begin n_err++; $display("FAIL len_err_flag[%0d]: got %b want 1", lens[j], o_Error); end
            n_vec++; if (o_CpuHold !== 1'b1) begin n_err++; $display("FAIL len_err_hold[%0d]: got %b want 1", lens[j], o_CpuHold); end
            n_vec++; if (o_ByteReady !== 1'b0) begin n_err++; $display("FAIL len_err_ready[%0d]: got %b want 0", lens[j], o_ByteReady); end
            repeat (4) begin @(posedge i_Clk); #1; end
            n_vec++; if (wq_addr.size() !== 0) begin n_err++; $display("FAIL len_err_writes[%0d]: got %0d want 0", lens[j], wq_addr.size()); end
            n_vec++; if (o_Error !== 1'b1 || o_Done !== 1'b0) begin n_err++; $display("FAIL len_err_sticky[%0d]: got err=%b done=%b want err=1 done=0", lens[j], o_Error, o_Done); end
        end
        i_ByteValid = 1'b0;
    endtask

    // Image loads checked against the model image (bytes then zeros).
    task automatic test_image_loads();
        int len, vm, expd;
        bit pk, exph;
        for (int s = 0; s < 11; s++) begin
            for (int i = 0; i < D; i++) img[i] = 8'($urandom);
            case (s)
                0: begin len = 0;  vm = 0; pk = 1'b0; end
                1: begin len = 4;  vm = 0; pk = 1'b0;
                         img[0] = 8'h00; img[1] = 8'h20; img[2] = 8'h01; img[3] = 8'hB3; end
                2: begin len = 8;  vm = 1; pk = 1'b0; end
                3: begin len = 32; vm = 0; pk = 1'b0; end
                4: begin len = 12; vm = 2; pk = 1'b1; end
                5: begin len = 32; vm = 1; pk = 1'b1; end
                default: begin len = 4 * $urandom_range(0, 8); vm = $urandom_range(0, 2); pk = 1'($urandom_range(0, 1)); end
            endcase
            run_load(len, vm, pk, -1);
            n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL load%0d_stream_timeout: got %b want 0", s, timed_out); end
            n_vec++; if (post_hold !== 1'b1 || post_done !== 1'b0) begin n_err++; $display("FAIL load%0d_start_hold: got hold=%b done=%b want hold=1 done=0", s, post_hold, post_done); end
            n_vec++; if (post_err !== 1'b0) begin n_err++; $display("FAIL load%0d_start_err_clear: got %b want 0", s, post_err); end
            n_vec++; if (wq_addr.size() !== D) begin n_err++; $display("FAIL load%0d_write_count: got %0d want %0d", s, wq_addr.size(), D); end
            for (int i = 0; i < wq_addr.size() && i < D; i++) begin
                expd = (i < len) ? int'(img[i]) : 0;
                exph = (i < len);
                n_vec++;
                if (wq_addr[i] !== i || wq_data[i] !== expd || wq_hs[i] !== exph) begin
                    n_err++;
                    $display("FAIL load%0d_write[%0d]: got addr=%0d data=%0h hs=%b want addr=%0d data=%0h hs=%b",
                             s, i, wq_addr[i], wq_data[i], wq_hs[i], i, expd, exph);
                end
            end
            if (wq_cyc.size() > 0) begin
                n_vec++; if (done_rise - wq_cyc[$] !== 1) begin n_err++; $display("FAIL load%0d_done_timing: got %0d want 1", s, done_rise - wq_cyc[$]); end
                n_vec++; if (wq_cyc[$] - wq_cyc[0] !== D - 1 - ((len > 0 && len < D) ? 0 : 0) && vm == 0 && len == D) begin n_err++; $display("FAIL load%0d_full_back_to_back: got %0d want %0d", s, wq_cyc[$] - wq_cyc[0], D - 1); end
            end
            n_vec++; if (o_Done !== 1'b1 || o_CpuHold !== 1'b0) begin n_err++; $display("FAIL load%0d_done_state: got done=%b hold=%b want done=1 hold=0", s, o_Done, o_CpuHold); end
            n_vec++; if (o_MemWrEn !== 1'b0 || o_ByteReady !== 1'b0 || o_Error !== 1'b0) begin n_err++; $display("FAIL load%0d_done_quiet: got wren=%b ready=%b err=%b want 0 0 0", s, o_MemWrEn, o_ByteReady, o_Error); end
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < D; i++) img[i] = 8'($urandom);
        clear_log();
        i_Start = 1'b1; i_Length = 6'd8;
        @(posedge i_Clk); #1;
        i_Start = 1'b0; i_ByteValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_ByteData = img[k];
            @(posedge i_Clk); #1;
        end
        i_Reset = 1'b1; i_ByteData = img[3];
        @(posedge i_Clk); #1;
        n_vec++; if (o_MemWrEn !== 1'b0) begin n_err++; $display("FAIL midreset_wren: got %b want 0", o_MemWrEn); end
        n_vec++; if (o_ByteReady !== 1'b0) begin n_err++; $display("FAIL midreset_ready: got %b want 0", o_ByteReady); end
        n_vec++; if (o_CpuHold !== 1'b1 || o_Done !== 1'b0) begin n_err++; $display("FAIL midreset_hold: got hold=%b done=%b want 1 0", o_CpuHold, o_Done); end
        n_vec++; if (o_MemWrAddr !== 5'd0) begin n_err++; $display("FAIL midreset_addr: got %0d want 0", o_MemWrAddr); end
        n_vec++; if (wq_addr.size() !== 3) begin n_err++; $display("FAIL midreset_partial_count: got %0d want 3", wq_addr.size()); end
        for (int i = 0; i < wq_addr.size() && i < 3; i++) begin
            n_vec++; if (wq_addr[i] !== i || wq_data[i] !== int'(img[i])) begin n_err++; $display("FAIL midreset_partial[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq_addr[i], wq_data[i], i, img[i]); end
        end
        i_Reset = 1'b0;
        repeat (4) begin @(posedge i_Clk); #1; end
        n_vec++; if (wq_addr.size() !== 3) begin n_err++; $display("FAIL midreset_no_more_writes: got %0d want 3", wq_addr.size()); end
        n_vec++; if (o_ByteReady !== 1'b0 || o_CpuHold !== 1'b1) begin n_err++; $display("FAIL midreset_idle: got ready=%b hold=%b want 0 1", o_ByteReady, o_CpuHold); end
        i_ByteValid = 1'b0;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int sum, bad;
        img[0] = 8'h00; img[1] = 8'h20; img[2] = 8'h01; img[3] = 8'hB3;
        run_load(4, 0, 1'b0, 8'h2C);
        n_vec++; if (o_Done !== 1'b1 || o_Error !== 1'b0) begin n_err++; $display("FAIL csum_good: got done=%b err=%b want 1 0", o_Done, o_Error); end
        n_vec++; if (wq_addr.size() !== D) begin n_err++; $display("FAIL csum_good_writes: got %0d want %0d", wq_addr.size(), D); end
        run_load(4, 0, 1'b0, 8'h2D);
        n_vec++; if (o_Error !== 1'b1 || o_Done !== 1'b0 || o_CpuHold !== 1'b1) begin n_err++; $display("FAIL csum_bad: got err=%b done=%b hold=%b want 1 0 1", o_Error, o_Done, o_CpuHold); end
        n_vec++; if (wq_addr.size() !== 4) begin n_err++; $display("FAIL csum_bad_writes: got %0d want 4", wq_addr.size()); end
        n_vec++; if (o_ByteReady !== 1'b0) begin n_err++; $display("FAIL csum_bad_idle: got %b want 0", o_ByteReady); end
        for (int i = 0; i < D; i++) img[i] = 8'($urandom);
        sum = 0;
        for (int i = 0; i < 16; i++) sum += int'(img[i]);
        bad = ((256 - (sum % 256)) + $urandom_range(1, 255)) % 256;
        run_load(16, 2, 1'b1, bad);
        n_vec++; if (o_Error !== 1'b1 || o_Done !== 1'b0) begin n_err++; $display("FAIL csum_rand_bad: got err=%b done=%b want 1 0", o_Error, o_Done); end
        n_vec++; if (wq_addr.size() !== 16) begin n_err++; $display("FAIL csum_rand_bad_writes: got %0d want 16", wq_addr.size()); end
    endtask
`endif

    initial begin
        i_Reset = 1'b1; i_Start = 1'b0; i_Length = '0;
        i_ByteValid = 1'b0; i_ByteData = '0;
        test_reset();
        test_length_errors();
        test_image_loads();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
